// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases core_reset_n.
// Outputs are registered with the state; lock input adds 2 cycles of synchronizer latency. No backpressure.
// Define PLL_SEQ_AUTO_RELOCK_EN to restart automatically on lock loss in RUN instead of latching FAULT.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 74250,
    parameter int MAX_RETRIES         = 4
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lost_lock_cnt
);
    localparam int PW = (RST_PULSE_CYCLES > 1)    ? $clog2(RST_PULSE_CYCLES)    : 1;
    localparam int SW = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 1)         ? $clog2(MAX_RETRIES)         : 1;

    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    // The locked sample that moves WAIT_LOCK into STABLE counts as the first stable cycle.
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 2);

    typedef enum logic [2:0] {
        ASSERT_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t          state, state_nxt;
    logic            sync1, locked_s;
    logic [PW-1:0]   pulse_cnt, pulse_nxt;
    logic [SW-1:0]   stable_cnt, stable_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [RW-1:0]   retry_cnt, retry_nxt;
    logic [7:0]      lost_nxt;

    always_comb begin
        state_nxt  = state;
        pulse_nxt  = pulse_cnt;
        stable_nxt = stable_cnt;
        timer_nxt  = timer;
        retry_nxt  = retry_cnt;
        lost_nxt   = lost_lock_cnt;
        case (state)
            ASSERT_RST: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else begin
                    pulse_nxt = pulse_cnt + PW'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    if (LOCK_STABLE_CYCLES == 1) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end else begin
                        state_nxt  = STABLE;
                        stable_nxt = '0;
                    end
                end else if (timer == TIMER_LAST) begin
                    if (int'(retry_cnt) + 1 == MAX_RETRIES) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = ASSERT_RST;
                        retry_nxt = retry_cnt + RW'(1);
                        pulse_nxt = '0;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end else begin
                    stable_nxt = stable_cnt + SW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    if (lost_lock_cnt != 8'hFF) begin
                        lost_nxt = lost_lock_cnt + 8'd1;
                    end
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                    state_nxt = ASSERT_RST;
                    pulse_nxt = '0;
                    retry_nxt = '0;
`else
                    state_nxt = FAULT;
`endif
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = ASSERT_RST;
                pulse_nxt = '0;
            end
        endcase
        // A relock request wins over any same-cycle timeout, lock or loss event.
        if (relock_req) begin
            state_nxt = ASSERT_RST;
            pulse_nxt = '0;
            retry_nxt = '0;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b0;
            locked_s      <= 1'b0;
            state         <= ASSERT_RST;
            pulse_cnt     <= '0;
            stable_cnt    <= '0;
            timer         <= '0;
            retry_cnt     <= '0;
            lost_lock_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            core_reset_n  <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            sync1         <= pll_locked;
            locked_s      <= sync1;
            state         <= state_nxt;
            pulse_cnt     <= pulse_nxt;
            stable_cnt    <= stable_nxt;
            timer         <= timer_nxt;
            retry_cnt     <= retry_nxt;
            lost_lock_cnt <= lost_nxt;
            pll_rst       <= (state_nxt == ASSERT_RST) || (state_nxt == FAULT);
            core_reset_n  <= (state_nxt == RUN);
            ready         <= (state_nxt == RUN);
            fault         <= (state_nxt == FAULT);
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters; builds with or without
// PLL_SEQ_AUTO_RELOCK_EN and picks the matching expectations for lock loss in RUN.
module tb_pll_reset_sequencer;
    logic       clk_74a = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       core_reset_n;
    logic       ready;
    logic       fault;
    logic [7:0] lost_lock_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk_74a = ~clk_74a;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .ready        (ready),
        .fault        (fault),
        .lost_lock_cnt(lost_lock_cnt)
    );

    // Observed outputs packed as {pll_rst, core_reset_n, ready, fault, lost_lock_cnt}.
    logic [11:0] obs;
    assign obs = {pll_rst, core_reset_n, ready, fault, lost_lock_cnt};

    localparam logic [11:0] O_IDLE = 12'h000;
    localparam logic [11:0] O_RST  = 12'h800;
    localparam logic [11:0] O_RUN  = 12'h600;
    localparam logic [11:0] O_FLT  = 12'h900;

    typedef struct {
        int          cyc;
        logic        lk;
        logic        rq;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_74a);
    endtask

    task automatic apply_reset(input logic lock);
        @(negedge clk_74a);
        relock_req = 1'b0;
        pll_locked = lock;
        reset_n    = 1'b0;
        #1;
        chk("reset_vals", obs, O_RST);
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input logic want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_74a);
            if (ready == want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic lose_and_recover();
        bit ok;
        pll_locked = 1'b0;
        wait_ready(1'b0, 8, ok);
        chk("loss_seen", ok, 1);
        pll_locked = 1'b1;
        if (fault) begin
            relock_req = 1'b1;
            step(1);
            relock_req = 1'b0;
        end
        wait_ready(1'b1, 40, ok);
        chk("recover", ok, 1);
    endtask

    initial begin
        bit ok;
        vecs[0]  = '{3, 1'b0, 1'b0, O_RST,  "pulse_hi"};
        vecs[1]  = '{1, 1'b0, 1'b0, O_IDLE, "pulse_end"};
        vecs[2]  = '{6, 1'b0, 1'b0, O_IDLE, "wait_nolock"};
        vecs[3]  = '{9, 1'b1, 1'b0, O_IDLE, "stable_hold"};
        vecs[4]  = '{1, 1'b1, 1'b0, O_RUN,  "run_entry"};
        vecs[5]  = '{5, 1'b1, 1'b0, O_RUN,  "run_hold"};
        vecs[6]  = '{1, 1'b1, 1'b1, O_RST,  "relock_run"};
        vecs[7]  = '{3, 1'b1, 1'b0, O_RST,  "relock_pulse"};
        vecs[8]  = '{1, 1'b1, 1'b0, O_IDLE, "relock_pulse_end"};
        vecs[9]  = '{7, 1'b1, 1'b0, O_IDLE, "relock_stable"};
        vecs[10] = '{1, 1'b1, 1'b0, O_RUN,  "relock_run_again"};

        // Normal bring-up, then relock from RUN.
        apply_reset(1'b0);
        for (int i = 0; i < 11; i++) begin
            pll_locked = vecs[i].lk;
            relock_req = vecs[i].rq;
            step(vecs[i].cyc);
            chk(vecs[i].name, obs, vecs[i].exp);
        end

        // Lock loss in RUN.
        pll_locked = 1'b0;
        step(2);
        chk("loss_pre", obs, O_RUN);
        step(1);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        chk("loss_autorelock", obs, 12'h801);
        pll_locked = 1'b1;
        step(3);
        chk("auto_pulse", obs, 12'h801);
        step(1);
        chk("auto_pulse_end", obs, 12'h001);
        step(7);
        chk("auto_stable", obs, 12'h001);
        step(1);
        chk("auto_run", obs, 12'h601);
`else
        chk("loss_fault", obs, 12'h901);
        step(5);
        chk("loss_fault_hold", obs, 12'h901);
`endif

        // No lock ever: two attempts, then FAULT.
        apply_reset(1'b0);
        step(35);
        chk("timeout1_wait", obs, O_IDLE);
        step(1);
        chk("retry_pulse", obs, O_RST);
        step(3);
        chk("retry_pulse_hold", obs, O_RST);
        step(1);
        chk("retry_pulse_end", obs, O_IDLE);
        step(31);
        chk("timeout2_wait", obs, O_IDLE);
        step(1);
        chk("fault_entry", obs, O_FLT);
        step(10);
        chk("fault_hold", obs, O_FLT);

        // Relock from FAULT with lock already present.
        pll_locked = 1'b1;
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk("fault_relock", obs, O_RST);
        step(3);
        chk("fault_relock_pulse", obs, O_RST);
        step(1);
        chk("fault_relock_pulse_end", obs, O_IDLE);
        step(7);
        chk("fault_relock_stable", obs, O_IDLE);
        step(1);
        chk("fault_relock_run", obs, O_RUN);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk("run_relock_drop", obs, O_RST);
        step(11);
        chk("run_relock_stable", obs, O_IDLE);
        step(1);
        chk("run_relock_run", obs, O_RUN);

        // One-cycle lock glitch in STABLE restarts the stability count.
        apply_reset(1'b1);
        step(9);
        chk("glitch_pre", obs, O_IDLE);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("glitch_blocks_run", obs, O_IDLE);
        step(7);
        chk("glitch_restable", obs, O_IDLE);
        step(1);
        chk("glitch_run", obs, O_RUN);

        // Saturate the lost-lock counter.
        for (int i = 0; i < 255; i++) begin
            lose_and_recover();
        end
        chk("lost_255", lost_lock_cnt, 255);
        pll_locked = 1'b0;
        wait_ready(1'b0, 8, ok);
        chk("loss_256_seen", ok, 1);
        chk("lost_saturated", lost_lock_cnt, 255);
        pll_locked = 1'b1;
        if (fault) begin
            relock_req = 1'b1;
            step(1);
            relock_req = 1'b0;
        end
        wait_ready(1'b1, 40, ok);
        chk("sat_recover", ok, 1);

        // Asynchronous reset in the middle of STABLE.
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        step(6);
        chk("mid_stable", obs, 12'h0FF);
        @(posedge clk_74a);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", obs, O_RST);
        step(2);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
